// File: rtl/interval_timer_pkg.sv
// Shared types and constants for the multi-channel interval timer.
// Holds the channel state encoding, the mode constants and the prescaler width helper.
package interval_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ch_state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // A divide-by-1 prescaler still needs a 1-bit register to stay well formed.
    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/interval_timer_ch.sv
// One timer channel: IDLE/RUN/DONE state machine, tick down-counter and
// the sticky pending/overrun flags that expiry raises.
module interval_timer_ch
    import interval_timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [CNT_W-1:0] interval_i,
    input  logic             mode_i,
    input  logic             enable_i,
    input  logic             ack_i,
    output logic             pending_o,
    output logic             overrun_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             expire;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        expire  = 1'b0;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (interval_i != '0) begin
                        state_d = RUN;
                        cnt_d   = interval_i;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (cnt_q > CNT_W'(1)) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end else begin
                            expire = 1'b1;
                            // The reload samples the interval live, so a zero here parks the channel.
                            if (mode_i == MODE_PERIODIC) begin
                                if (interval_i != '0) begin
                                    cnt_d = interval_i;
                                end else begin
                                    state_d = IDLE;
                                end
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (ack_i) begin
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end
        // An expiry that coincides with an ack sets pending but cannot count as an overrun.
        if (expire) begin
            pending_d = 1'b1;
            if (pending_q && !ack_i) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending_o = pending_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/interval_timer_mc.sv
// Multi-channel interval timer top: shared free-running prescaler, NUM_CH
// channel instances and the gated, registered interrupt line.
module interval_timer_mc
    import interval_timer_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 16,
    parameter int PRESCALE_DIV = 65536
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic [NUM_CH*CNT_W-1:0] interval_i,
    input  logic [NUM_CH-1:0]       mode_i,
    input  logic [NUM_CH-1:0]       enable_i,
    input  logic [NUM_CH-1:0]       irq_ack_i,
    input  logic                    interrupt_en,
    output logic [NUM_CH-1:0]       irq_pending_o,
    output logic [NUM_CH-1:0]       overrun_o,
    output logic                    interrupt_o
);

    localparam int                 PRESC_W   = presc_width(PRESCALE_DIV);
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;
    logic [NUM_CH-1:0]  pending;
    logic [NUM_CH-1:0]  overrun;
    logic               interrupt_q, interrupt_d;

    assign tick = (presc_q == PRESC_MAX);

    // The prescaler is never restarted by channels, so first-period latency depends on its phase.
    always_comb begin
        presc_d = presc_q + PRESC_W'(1);
        if (tick) begin
            presc_d = '0;
        end
        interrupt_d = interrupt_en & (|pending);
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            presc_q     <= '0;
            interrupt_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            interrupt_q <= interrupt_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
        interval_timer_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (ap_clk),
            .rst_n      (ap_rst_n),
            .tick       (tick),
            .interval_i (interval_i[c*CNT_W +: CNT_W]),
            .mode_i     (mode_i[c]),
            .enable_i   (enable_i[c]),
            .ack_i      (irq_ack_i[c]),
            .pending_o  (pending[c]),
            .overrun_o  (overrun[c])
        );
    end

    assign irq_pending_o = pending;
    assign overrun_o     = overrun;
    assign interrupt_o   = interrupt_q;

endmodule

// File: tb/tb_interval_timer_mc.sv
// Directed self-checking bench for interval_timer_mc: a 2-channel, divide-by-4
// instance for the functional scenarios and a 1-channel, divide-by-1 instance for the long count.
module tb_interval_timer_mc;
    import interval_timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] interval;
    logic [1:0]  mode;
    logic [1:0]  enable;
    logic [1:0]  ack;
    logic        int_en;
    logic [1:0]  pend;
    logic [1:0]  ovr;
    logic        irq;

    logic        rst2_n;
    logic [15:0] interval2;
    logic [0:0]  mode2;
    logic [0:0]  enable2;
    logic [0:0]  ack2;
    logic        int_en2;
    logic [0:0]  pend2;
    logic [0:0]  ovr2;
    logic        irq2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    interval_timer_mc #(
        .NUM_CH       (2),
        .CNT_W        (8),
        .PRESCALE_DIV (4)
    ) u_dut (
        .ap_clk        (clk),
        .ap_rst_n      (rst_n),
        .interval_i    (interval),
        .mode_i        (mode),
        .enable_i      (enable),
        .irq_ack_i     (ack),
        .interrupt_en  (int_en),
        .irq_pending_o (pend),
        .overrun_o     (ovr),
        .interrupt_o   (irq)
    );

    interval_timer_mc #(
        .NUM_CH       (1),
        .CNT_W        (16),
        .PRESCALE_DIV (1)
    ) u_dut2 (
        .ap_clk        (clk),
        .ap_rst_n      (rst2_n),
        .interval_i    (interval2),
        .mode_i        (mode2),
        .enable_i      (enable2),
        .irq_ack_i     (ack2),
        .interrupt_en  (int_en2),
        .irq_pending_o (pend2),
        .overrun_o     (ovr2),
        .interrupt_o   (irq2)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        enable = 2'b00;
        ack    = 2'b00;
        step(3);
        rst_n  = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        bad      = 0;
        rst_n    = 1'b0;
        interval = {8'd0, 8'd3};
        mode     = 2'b00;
        enable   = 2'b11;
        ack      = 2'b00;
        int_en   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if ({pend, ovr, irq} !== 5'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++;
            $display("[TB] FAIL reset_quiet: got %0d active cycles, expected 0", bad);
        end
        n_cmp++;
        if (pend !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL reset_pending: got %b, expected 00", pend);
        end
        n_cmp++;
        if (ovr !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL reset_overrun: got %b, expected 00", ovr);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_irq: got %b, expected 0", irq);
        end
        int_en = 1'b0;
    endtask

    task automatic test_periodic();
        int first;
        int j;
        first = -1;
        rst_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (pend[0]) begin
                first = i - 1;
                break;
            end
        end
        n_cmp++;
        if (first < 9 || first > 12) begin
            n_err++;
            $display("[TB] FAIL periodic_first: got %0d cycles, expected 9..12", first);
        end
        for (int k = 0; k < 2; k++) begin
            ack[0] = 1'b1;
            step(1);
            ack[0] = 1'b0;
            j = -1;
            for (int i = 1; i <= 20; i++) begin
                step(1);
                if (pend[0]) begin
                    j = i;
                    break;
                end
            end
            n_cmp++;
            if (j + 1 !== 12) begin
                n_err++;
                $display("[TB] FAIL periodic_period%0d: got %0d cycles, expected 12", k, j + 1);
            end
        end
        n_cmp++;
        if (pend[1] !== 1'b0 || ovr !== 2'b00) begin
            n_err++;
            $display("[TB] FAIL periodic_side: got pend1=%b ovr=%b, expected 0 and 00", pend[1], ovr);
        end
    endtask

    task automatic test_oneshot();
        int cnt;
        logic prev;
        apply_reset();
        interval = {8'd2, 8'd0};
        mode     = 2'b10;
        enable   = 2'b10;
        cnt      = 0;
        prev     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            ack[1] = 1'b0;
            if (pend[1] && !prev) begin
                cnt++;
                ack[1] = 1'b1;
            end
            prev = pend[1];
        end
        n_cmp++;
        if (cnt !== 1) begin
            n_err++;
            $display("[TB] FAIL oneshot_count: got %0d expiries, expected 1", cnt);
        end
        n_cmp++;
        if (u_dut.gen_ch[1].u_ch.state_q !== DONE) begin
            n_err++;
            $display("[TB] FAIL oneshot_state: got %0d, expected %0d", int'(u_dut.gen_ch[1].u_ch.state_q), int'(DONE));
        end
        ack[1]    = 1'b0;
        enable[1] = 1'b0;
        step(1);
        enable[1] = 1'b1;
        cnt       = 0;
        prev      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            ack[1] = 1'b0;
            if (pend[1] && !prev) begin
                cnt++;
                ack[1] = 1'b1;
            end
            prev = pend[1];
        end
        ack[1] = 1'b0;
        n_cmp++;
        if (cnt !== 1) begin
            n_err++;
            $display("[TB] FAIL oneshot_rearm: got %0d expiries, expected 1", cnt);
        end
    endtask

    task automatic test_overrun();
        int seen;
        apply_reset();
        interval = {8'd0, 8'd1};
        mode     = 2'b00;
        enable   = 2'b01;
        seen     = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (pend[0]) begin
                seen = 1;
                break;
            end
        end
        n_cmp++;
        if (seen !== 1 || ovr[0] !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL overrun_first: got seen=%0d ovr=%b, expected 1 and 0", seen, ovr[0]);
        end
        step(4);
        n_cmp++;
        if (ovr[0] !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL overrun_second: got %b, expected 1", ovr[0]);
        end
        step(3);
        ack[0] = 1'b1;
        step(1);
        ack[0] = 1'b0;
        n_cmp++;
        if (pend[0] !== 1'b1 || ovr[0] !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL overrun_ack_collide: got pend=%b ovr=%b, expected 1 and 0", pend[0], ovr[0]);
        end
    endtask

    task automatic test_irq_gate();
        int seen;
        apply_reset();
        int_en   = 1'b0;
        interval = {8'd0, 8'd1};
        mode     = 2'b01;
        enable   = 2'b01;
        seen     = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (pend[0]) begin
                seen = 1;
                break;
            end
        end
        step(2);
        n_cmp++;
        if (seen !== 1 || irq !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL irq_gated: got seen=%0d irq=%b, expected 1 and 0", seen, irq);
        end
        int_en = 1'b1;
        step(1);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL irq_enable_rise: got %b, expected 1", irq);
        end
        ack[0] = 1'b1;
        step(1);
        ack[0] = 1'b0;
        n_cmp++;
        if (pend[0] !== 1'b0 || irq !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL irq_ack_lag: got pend=%b irq=%b, expected 0 and 1", pend[0], irq);
        end
        step(1);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL irq_fall: got %b, expected 0", irq);
        end
        int_en = 1'b0;
    endtask

    task automatic test_interval_change();
        int hits;
        int first;
        int j;
        apply_reset();
        interval = 16'd0;
        mode     = 2'b00;
        enable   = 2'b01;
        hits     = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (pend[0]) hits++;
        end
        n_cmp++;
        if (hits !== 0) begin
            n_err++;
            $display("[TB] FAIL zero_interval: got %0d pending cycles, expected 0", hits);
        end
        interval[7:0] = 8'd5;
        first = -1;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (i == 6) interval[7:0] = 8'd2;
            if (pend[0]) begin
                first = i - 1;
                break;
            end
        end
        n_cmp++;
        if (first < 17 || first > 20) begin
            n_err++;
            $display("[TB] FAIL change_old_period: got %0d cycles, expected 17..20", first);
        end
        ack[0] = 1'b1;
        step(1);
        ack[0] = 1'b0;
        j = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            if (pend[0]) begin
                j = i;
                break;
            end
        end
        n_cmp++;
        if (j + 1 !== 8) begin
            n_err++;
            $display("[TB] FAIL change_new_period: got %0d cycles, expected 8", j + 1);
        end
        enable = 2'b00;
    endtask

    task automatic test_long_and_reset();
        int cycles;
        interval2 = 16'hFFFF;
        mode2     = 1'b0;
        enable2   = 1'b1;
        ack2      = 1'b0;
        int_en2   = 1'b1;
        rst2_n    = 1'b1;
        cycles    = -1;
        for (int i = 1; i <= 70000; i++) begin
            step(1);
            if (pend2[0]) begin
                cycles = i - 1;
                break;
            end
        end
        n_cmp++;
        if (cycles !== 65535) begin
            n_err++;
            $display("[TB] FAIL long_expiry: got %0d cycles, expected 65535", cycles);
        end
        step(50);
        n_cmp++;
        if (pend2[0] !== 1'b1 || irq2 !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL long_before_reset: got pend=%b irq=%b, expected 1 and 1", pend2[0], irq2);
        end
        rst2_n = 1'b0;
        step(1);
        n_cmp++;
        if (pend2[0] !== 1'b0 || ovr2[0] !== 1'b0 || irq2 !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL midcount_reset_out: got pend=%b ovr=%b irq=%b, expected 0 0 0", pend2[0], ovr2[0], irq2);
        end
        n_cmp++;
        if (u_dut2.gen_ch[0].u_ch.state_q !== IDLE || u_dut2.gen_ch[0].u_ch.cnt_q !== 16'd0) begin
            n_err++;
            $display("[TB] FAIL midcount_reset_state: got state=%0d cnt=%0d, expected 0 and 0",
                     int'(u_dut2.gen_ch[0].u_ch.state_q), u_dut2.gen_ch[0].u_ch.cnt_q);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        interval  = '0;
        mode      = '0;
        enable    = '0;
        ack       = '0;
        int_en    = 1'b0;
        rst2_n    = 1'b0;
        interval2 = '0;
        mode2     = '0;
        enable2   = '0;
        ack2      = '0;
        int_en2   = 1'b0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_overrun();
        test_irq_gate();
        test_interval_change();
        test_long_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/interval_timer_mc.md
# interval_timer_mc

Multi-channel interval timer: the parametrised successor of the single-channel `interval_timer`. A shared free-running prescaler drives NUM_CH independent down-counters. Each channel runs in periodic or one-shot mode and raises a sticky pending flag on expiry; the flags combine into one gated interrupt line. The block sits beside the HLS cores on `ap_clk` and feeds the PS interrupt controller.

## Interface
- `NUM_CH`, 4, number of timer channels (1..16)
- `CNT_W`, 16, interval/counter width in ticks
- `PRESCALE_DIV`, 65536, `ap_clk` cycles per tick (>=1; 1 = tick every cycle)
- `ap_clk`  in  1  clock; all logic on rising edge
- `ap_rst_n`  in  1  reset, synchronous, active-low
- `interval_i`  in  NUM_CH*CNT_W  per-channel interval in ticks; channel c at bits [c*CNT_W +: CNT_W]
- `mode_i`  in  NUM_CH  per channel: 0 = periodic, 1 = one-shot
- `enable_i`  in  NUM_CH  per-channel run enable (level)
- `irq_ack_i`  in  NUM_CH  per-channel pending/overrun clear (pulse)
- `interrupt_en`  in  1  global interrupt gate
- `irq_pending_o`  out  NUM_CH  sticky expiry flags
- `overrun_o`  out  NUM_CH  sticky: expiry occurred while pending already set
- `interrupt_o`  out  1  registered, `interrupt_en & |irq_pending_o`

## Operation
- Prescaler: counts 0..PRESCALE_DIV-1, wraps, free-running from reset; `tick` = (count == PRESCALE_DIV-1). It is shared and never restarted by channel enables.
- Channel FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when `enable_i[c]=1` and `interval_i[c]!=0`; counter loads `interval_i[c]`.
  - If `interval_i[c]==0`, stay IDLE; the channel never expires.
  - RUN, tick, cnt>1: cnt--.
  - RUN, tick, cnt==1: expire.
    - Periodic: reload cnt from current `interval_i[c]`, stay RUN. If the new interval is 0, go IDLE.
    - One-shot: go DONE.
  - DONE -> IDLE when `enable_i[c]=0`. No re-arm while enable is held.
  - Any state, `enable_i[c]=0`: go IDLE next edge. Pending/overrun are kept.
- `interval_i` changes during RUN take effect only at the next load/reload.
- Expiry sets `irq_pending_o[c]`. If pending is already 1, expiry also sets `overrun_o[c]`.
- `irq_ack_i[c]` clears both pending and overrun. If expiry and ack land in the same cycle, set wins: pending=1, overrun=0.
- `interrupt_en` gates only `interrupt_o`. Counting and pending flags run regardless.

## Timing
- Reset values: prescaler 0, all channels IDLE, cnt 0, `irq_pending_o`=0, `overrun_o`=0, `interrupt_o`=0.
- Reset is honoured mid-count and overrides every other input in the same edge.
- Enable to load: 1 edge.
- First expiry comes interval-1 full ticks plus one partial tick (1..PRESCALE_DIV cycles) after load. Later periodic expiries are exactly interval*PRESCALE_DIV cycles apart.
- Pending flag: set on the edge where tick and cnt==1 coincide.
- `interrupt_o`: rises 1 cycle after pending is set, or 1 cycle after `interrupt_en` rises with pending already set. Falls 1 cycle after the last pending clears or `interrupt_en` drops.
- Arithmetic: cnt is CNT_W unsigned and never decrements below 1. Max interval = 2^CNT_W-1 ticks. Prescaler width = $clog2(PRESCALE_DIV), minimum 1.

## Structure
- Package `interval_timer_pkg`: channel state enum (IDLE/RUN/DONE) and mode constants (MODE_PERIODIC=0, MODE_ONESHOT=1).
- Sub-module `interval_timer_ch`: one channel (FSM, counter, pending/overrun). Generated NUM_CH times.
- The top holds the prescaler, the interrupt OR/gate and the output register.

## Test plan
Use PRESCALE_DIV=4, NUM_CH=2, CNT_W=8 unless stated.
1. Reset held 20 cycles with enables high -> all outputs 0, no expiry. Release, ch0 periodic interval 3 -> pending pulses every 12 cycles once acked each time; first expiry within 9..12 cycles of load.
2. ch1 one-shot interval 2, enable held 100 cycles -> exactly one expiry, state DONE. Drop and re-raise enable -> second expiry.
3. ch0 periodic interval 1, never acked -> overrun=1 on second expiry. Ack in the same cycle as a third expiry -> pending=1, overrun=0.
4. `interrupt_en`=0 while pending=1 -> `interrupt_o` stays 0. Raise `interrupt_en` -> `interrupt_o`=1 one cycle later. Ack -> `interrupt_o`=0 one cycle after pending clears.
5. interval 0 with enable=1 -> never expires. Change interval 5 -> 2 mid-RUN -> current period uses 5, next uses 2.
6. PRESCALE_DIV=1, CNT_W=16, interval 0xFFFF -> expiry after 65535 cycles. Assert reset mid-count -> all state cleared next edge.
